// File: rtl/parking_pkg.sv
`default_nettype none
// ============================================================================
// Module  : parking_pkg
// Purpose : Shared constants for the car-park exit gate controller:
//           exit FSM state encodings, default exit ticket codes and the
//           {gate, red, green} output patterns of the steady states.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package parking_pkg;

  // Exit FSM state encodings (3 bits)
  localparam logic [2:0] c_st_idle   = 3'b000;
  localparam logic [2:0] c_st_wait   = 3'b001;
  localparam logic [2:0] c_st_bad    = 3'b010;
  localparam logic [2:0] c_st_open   = 3'b011;
  localparam logic [2:0] c_st_locked = 3'b100;

  // Default ticket codes accepted at the exit
  localparam logic [1:0] c_exit_code_1 = 2'b10;
  localparam logic [1:0] c_exit_code_2 = 2'b01;

  // Output patterns ordered {gate_open, RED_LED, GREEN_LED}
  localparam logic [2:0] c_out_idle   = 3'b000;
  localparam logic [2:0] c_out_wait   = 3'b010;
  localparam logic [2:0] c_out_locked = 3'b011;

endpackage
`default_nettype wire

// File: rtl/parking_occupancy_counter.sv
`default_nettype none
// ============================================================================
// Module  : parking_occupancy_counter
// Purpose : Saturating up/down occupancy counter with full/empty flags.
//           An increment while full or a decrement while empty is dropped;
//           simultaneous increment and decrement leave the count unchanged.
// Ports   : clk, reset (async, active-low)
//           inc       - one-cycle increment request
//           dec       - one-cycle decrement request
//           occupancy - current count
//           full      - occupancy == CAPACITY
//           empty     - occupancy == 0
// Revision: 1.0 - initial release
// ============================================================================
module parking_occupancy_counter #(
  parameter int CAPACITY = 8,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] occupancy,
  output logic             full,
  output logic             empty
);

  logic [CNT_W-1:0] r_count;
  logic             w_full;
  logic             w_empty;

  assign w_full  = (r_count == CNT_W'(CAPACITY));
  assign w_empty = (r_count == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (inc && !dec) begin
      if (!w_full) r_count <= r_count + CNT_W'(1);
    end else if (dec && !inc) begin
      if (!w_empty) r_count <= r_count - CNT_W'(1);
    end
  end

  assign occupancy = r_count;
  assign full      = w_full;
  assign empty     = w_empty;

endmodule
`default_nettype wire

// File: rtl/parking_exit_gate.sv
`default_nettype none
// ============================================================================
// Module  : parking_exit_gate
// Purpose : Exit-side barrier controller. Tracks occupancy from entrance
//           pulses and exit passages, validates the 2x2-bit exit ticket and
//           drives the barrier and the red/green exit LEDs.
// Build   : define PARKING_EXIT_LOCKOUT_EN to enable the bad-ticket lockout
//           (MAX_BAD_TICKETS wrong strobes enter LOCKED).
// Ports   : clk, reset (async, active-low)
//           car_entered      - pulse from entrance: a car parked
//           sensor_exit_in   - car present at exit barrier (level)
//           sensor_exit_out  - car has passed the barrier (level)
//           ticket_1/2       - ticket fields, qualified by ticket_valid
//           gate_open        - barrier raise command (registered)
//           GREEN_LED/RED_LED- exit LEDs (registered)
//           occupancy/full/empty - car count and its flags
// Revision: 1.0 - initial release
// ============================================================================
module parking_exit_gate
  import parking_pkg::*;
#(
  parameter int         CAPACITY        = 8,
  parameter int         CNT_W           = 4,
  parameter int         TIMEOUT_CYC     = 4,
  parameter logic [1:0] EXIT_CODE_1     = c_exit_code_1,
  parameter logic [1:0] EXIT_CODE_2     = c_exit_code_2,
  parameter int         MAX_BAD_TICKETS = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             car_entered,
  input  logic             sensor_exit_in,
  input  logic             sensor_exit_out,
  input  logic [1:0]       ticket_1,
  input  logic [1:0]       ticket_2,
  input  logic             ticket_valid,
  output logic             gate_open,
  output logic             GREEN_LED,
  output logic             RED_LED,
  output logic [CNT_W-1:0] occupancy,
  output logic             full,
  output logic             empty
);

  localparam int c_wait_w = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  if (((1 << CNT_W) <= CAPACITY) || (TIMEOUT_CYC < 1) || (MAX_BAD_TICKETS < 1)) begin : g_param_check
    $error("parking_exit_gate: invalid parameter set");
  end

  logic [2:0]          r_state;
  logic [2:0]          w_next;
  logic [c_wait_w-1:0] r_wait;
  logic                w_good;
  logic                w_bad;
  logic                w_timeout;
  logic                w_lock;
  logic                w_exit;
  logic                w_empty;
  logic                r_gate;
  logic                r_red;
  logic                r_green;

  assign w_good    = ticket_valid && (ticket_1 == EXIT_CODE_1) && (ticket_2 == EXIT_CODE_2);
  assign w_bad     = ticket_valid && !w_good;
  assign w_timeout = (r_wait == c_wait_w'(TIMEOUT_CYC - 1));
  assign w_exit    = (r_state == c_st_open) && sensor_exit_out;

`ifdef PARKING_EXIT_LOCKOUT_EN
  localparam int c_bad_w = $clog2(MAX_BAD_TICKETS + 1);
  logic [c_bad_w-1:0] r_bad_cnt;
  logic               w_bad_counted;

  assign w_bad_counted = w_bad && ((r_state == c_st_wait) || (r_state == c_st_bad));
  // The strobe that would make the count reach MAX_BAD_TICKETS locks.
  assign w_lock = w_bad_counted && (r_bad_cnt == c_bad_w'(MAX_BAD_TICKETS - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bad_cnt <= '0;
    end else if ((w_next == c_st_idle) || (w_next == c_st_open)) begin
      r_bad_cnt <= '0;
    end else if (w_bad_counted) begin
      r_bad_cnt <= r_bad_cnt + c_bad_w'(1);
    end
  end
`else
  assign w_lock = 1'b0;
`endif

  // Next-state logic; WAIT priority is good > bad > sensor drop > timeout.
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_st_idle: begin
        if (sensor_exit_in && !w_empty) w_next = c_st_wait;
      end
      c_st_wait: begin
        if (w_good)               w_next = c_st_open;
        else if (w_bad)           w_next = w_lock ? c_st_locked : c_st_bad;
        else if (!sensor_exit_in) w_next = c_st_idle;
        else if (w_timeout)       w_next = c_st_bad;
      end
      c_st_bad: begin
        if (w_good)               w_next = c_st_open;
        else if (w_lock)          w_next = c_st_locked;
        else if (!sensor_exit_in) w_next = c_st_idle;
      end
      c_st_open: begin
        if (sensor_exit_out) w_next = c_st_idle;
      end
      c_st_locked: begin
        if (!sensor_exit_in) w_next = c_st_idle;
      end
      default: w_next = c_st_idle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= c_st_idle;
    else        r_state <= w_next;
  end

  // Wait counter runs only while remaining in WAIT_TICKET; entering it
  // from any other state starts the count at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                          r_wait <= '0;
    else if ((w_next == c_st_wait) && (r_state == c_st_wait)) r_wait <= r_wait + c_wait_w'(1);
    else                                                 r_wait <= '0;
  end

  // Outputs follow next state so they switch on the same edge as r_state.
  // Blinking LEDs start at 1 on entry and toggle while the state is held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      {r_gate, r_red, r_green} <= c_out_idle;
    end else begin
      case (w_next)
        c_st_wait:   {r_gate, r_red, r_green} <= c_out_wait;
        c_st_bad: begin
          r_gate  <= 1'b0;
          r_green <= 1'b0;
          r_red   <= (r_state == c_st_bad) ? !r_red : 1'b1;
        end
        c_st_open: begin
          r_gate  <= 1'b1;
          r_red   <= 1'b0;
          r_green <= (r_state == c_st_open) ? !r_green : 1'b1;
        end
        c_st_locked: {r_gate, r_red, r_green} <= c_out_locked;
        default:     {r_gate, r_red, r_green} <= c_out_idle;
      endcase
    end
  end

  assign gate_open = r_gate;
  assign RED_LED   = r_red;
  assign GREEN_LED = r_green;
  assign empty     = w_empty;

  parking_occupancy_counter #(
    .CAPACITY (CAPACITY),
    .CNT_W    (CNT_W)
  ) u_occupancy (
    .clk       (clk),
    .reset     (reset),
    .inc       (car_entered),
    .dec       (w_exit),
    .occupancy (occupancy),
    .full      (full),
    .empty     (w_empty)
  );

endmodule
`default_nettype wire

// File: tb/tb_parking_exit_gate.sv
`default_nettype none
// ============================================================================
// Module  : tb_parking_exit_gate
// Purpose : Directed self-checking bench for parking_exit_gate. Outputs are
//           observed 1 time unit after each rising edge as the pattern
//           {gate_open, RED_LED, GREEN_LED}.
// Revision: 1.0 - initial release
// ============================================================================
module tb_parking_exit_gate;

  logic       clk;
  logic       reset;
  logic       car_entered;
  logic       sensor_exit_in;
  logic       sensor_exit_out;
  logic [1:0] ticket_1;
  logic [1:0] ticket_2;
  logic       ticket_valid;
  logic       gate_open;
  logic       GREEN_LED;
  logic       RED_LED;
  logic [3:0] occupancy;
  logic       full;
  logic       empty;

  int errors;
  int checks;

  parking_exit_gate #(
    .CAPACITY        (8),
    .CNT_W           (4),
    .TIMEOUT_CYC     (4),
    .EXIT_CODE_1     (2'b10),
    .EXIT_CODE_2     (2'b01),
    .MAX_BAD_TICKETS (3)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .car_entered     (car_entered),
    .sensor_exit_in  (sensor_exit_in),
    .sensor_exit_out (sensor_exit_out),
    .ticket_1        (ticket_1),
    .ticket_2        (ticket_2),
    .ticket_valid    (ticket_valid),
    .gate_open       (gate_open),
    .GREEN_LED       (GREEN_LED),
    .RED_LED         (RED_LED),
    .occupancy       (occupancy),
    .full            (full),
    .empty           (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic good_ticket();
    ticket_1 = 2'b10; ticket_2 = 2'b01; ticket_valid = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; car_entered = 1'b0; sensor_exit_in = 1'b0; sensor_exit_out = 1'b0;
    ticket_1 = 2'b00; ticket_2 = 2'b00; ticket_valid = 1'b0;
    step(); step();
    checks++; if ({gate_open, RED_LED, GREEN_LED} !== 3'b000) begin errors++; $display("FAIL reset_outputs: got %b expected 000", {gate_open, RED_LED, GREEN_LED}); end
    checks++; if ({occupancy, full, empty} !== 6'b0000_0_1) begin errors++; $display("FAIL reset_occupancy: got occ=%0d full=%b empty=%b expected occ=0 full=0 empty=1", occupancy, full, empty); end
    reset = 1'b1;
    step();
  endtask

  task automatic test_empty_ignore();
    sensor_exit_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if ({gate_open, RED_LED, GREEN_LED} !== 3'b000) begin errors++; $display("FAIL empty_ignore[%0d]: got %b expected 000", i, {gate_open, RED_LED, GREEN_LED}); end
    end
    sensor_exit_in = 1'b0;
  endtask

  task automatic test_open_exit();
    car_entered = 1'b1; step(); step(); car_entered = 1'b0;
    checks++; if ({occupancy, empty} !== 5'b0010_0) begin errors++; $display("FAIL enter_two: got occ=%0d empty=%b expected occ=2 empty=0", occupancy, empty); end
    sensor_exit_in = 1'b1; step();
    checks++; if ({gate_open, RED_LED, GREEN_LED} !== 3'b010) begin errors++; $display("FAIL wait_leds: got %b expected 010", {gate_open, RED_LED, GREEN_LED}); end
    good_ticket(); step(); ticket_valid = 1'b0;
    checks++; if ({gate_open, RED_LED, GREEN_LED} !== 3'b101) begin errors++; $display("FAIL open_entry: got %b expected 101", {gate_open, RED_LED, GREEN_LED}); end
    step();
    checks++; if ({gate_open, RED_LED, GREEN_LED} !== 3'b100) begin errors++; $display("FAIL open_blink0: got %b expected 100", {gate_open, RED_LED, GREEN_LED}); end
    step();
    checks++; if ({gate_open, RED_LED, GREEN_LED} !== 3'b101) begin errors++; $display("FAIL open_blink1: got %b expected 101", {gate_open, RED_LED, GREEN_LED}); end
    sensor_exit_out = 1'b1; sensor_exit_in = 1'b0; step(); sensor_exit_out = 1'b0;
    checks++; if ({gate_open, RED_LED, GREEN_LED} !== 3'b000) begin errors++; $display("FAIL exit_idle: got %b expected 000", {gate_open, RED_LED, GREEN_LED}); end
    checks++; if (occupancy !== 4'd1) begin errors++; $display("FAIL exit_decrement: got %0d expected 1", occupancy); end
  endtask

  task automatic test_timeout();
    sensor_exit_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if ({gate_open, RED_LED, GREEN_LED} !== 3'b010) begin errors++; $display("FAIL timeout_wait[%0d]: got %b expected 010", i, {gate_open, RED_LED, GREEN_LED}); end
    end
    step();
    checks++; if ({gate_open, RED_LED, GREEN_LED} !== 3'b010) begin errors++; $display("FAIL bad_entry: got %b expected 010", {gate_open, RED_LED, GREEN_LED}); end
    step();
    checks++; if ({gate_open, RED_LED, GREEN_LED} !== 3'b000) begin errors++; $display("FAIL bad_blink0: got %b expected 000", {gate_open, RED_LED, GREEN_LED}); end
    step();
    checks++; if ({gate_open, RED_LED, GREEN_LED} !== 3'b010) begin errors++; $display("FAIL bad_blink1: got %b expected 010", {gate_open, RED_LED, GREEN_LED}); end
    good_ticket(); step(); ticket_valid = 1'b0;
    checks++; if ({gate_open, RED_LED, GREEN_LED} !== 3'b101) begin errors++; $display("FAIL bad_to_open: got %b expected 101", {gate_open, RED_LED, GREEN_LED}); end
    sensor_exit_out = 1'b1; sensor_exit_in = 1'b0; step(); sensor_exit_out = 1'b0;
    checks++; if ({occupancy, empty} !== 5'b0000_1) begin errors++; $display("FAIL timeout_exit_occ: got occ=%0d empty=%b expected occ=0 empty=1", occupancy, empty); end
  endtask

  task automatic test_full_saturate();
    car_entered = 1'b1;
    for (int i = 0; i < 8; i++) step();
    checks++; if ({occupancy, full} !== 5'b1000_1) begin errors++; $display("FAIL fill_eight: got occ=%0d full=%b expected occ=8 full=1", occupancy, full); end
    step(); car_entered = 1'b0;
    checks++; if ({occupancy, full} !== 5'b1000_1) begin errors++; $display("FAIL ninth_dropped: got occ=%0d full=%b expected occ=8 full=1", occupancy, full); end
    sensor_exit_in = 1'b1; step();
    good_ticket(); step(); ticket_valid = 1'b0;
    checks++; if (gate_open !== 1'b1) begin errors++; $display("FAIL full_open: got %b expected 1", gate_open); end
    car_entered = 1'b1; sensor_exit_out = 1'b1; sensor_exit_in = 1'b0; step();
    car_entered = 1'b0; sensor_exit_out = 1'b0;
    checks++; if ({occupancy, full, gate_open} !== 6'b1000_1_0) begin errors++; $display("FAIL inc_dec_same: got occ=%0d full=%b gate=%b expected occ=8 full=1 gate=0", occupancy, full, gate_open); end
    sensor_exit_in = 1'b1; step();
    good_ticket(); step(); ticket_valid = 1'b0;
    sensor_exit_out = 1'b1; sensor_exit_in = 1'b0; step(); sensor_exit_out = 1'b0;
    checks++; if ({occupancy, full} !== 5'b0111_0) begin errors++; $display("FAIL leave_full: got occ=%0d full=%b expected occ=7 full=0", occupancy, full); end
  endtask

  task automatic test_sensor_drop();
    sensor_exit_in = 1'b1; step();
    checks++; if ({gate_open, RED_LED, GREEN_LED} !== 3'b010) begin errors++; $display("FAIL drop_wait: got %b expected 010", {gate_open, RED_LED, GREEN_LED}); end
    sensor_exit_in = 1'b0; step();
    checks++; if ({gate_open, RED_LED, GREEN_LED} !== 3'b000) begin errors++; $display("FAIL drop_idle: got %b expected 000", {gate_open, RED_LED, GREEN_LED}); end
  endtask

  task automatic test_bad_tickets();
    sensor_exit_in = 1'b1; step();
    ticket_1 = 2'b00; ticket_2 = 2'b00; ticket_valid = 1'b1;
    step();
    checks++; if ({gate_open, RED_LED, GREEN_LED} !== 3'b010) begin errors++; $display("FAIL bad1: got %b expected 010", {gate_open, RED_LED, GREEN_LED}); end
    step();
    checks++; if ({gate_open, RED_LED, GREEN_LED} !== 3'b000) begin errors++; $display("FAIL bad2: got %b expected 000", {gate_open, RED_LED, GREEN_LED}); end
    step();
`ifdef PARKING_EXIT_LOCKOUT_EN
    checks++; if ({gate_open, RED_LED, GREEN_LED} !== 3'b011) begin errors++; $display("FAIL bad3_locked: got %b expected 011", {gate_open, RED_LED, GREEN_LED}); end
    good_ticket(); step(); ticket_valid = 1'b0;
    checks++; if ({gate_open, RED_LED, GREEN_LED} !== 3'b011) begin errors++; $display("FAIL locked_ignores_good: got %b expected 011", {gate_open, RED_LED, GREEN_LED}); end
    sensor_exit_in = 1'b0; step();
    checks++; if ({gate_open, RED_LED, GREEN_LED, occupancy} !== 7'b000_0111) begin errors++; $display("FAIL locked_release: got %b occ=%0d expected 000 occ=7", {gate_open, RED_LED, GREEN_LED}, occupancy); end
`else
    checks++; if ({gate_open, RED_LED, GREEN_LED} !== 3'b010) begin errors++; $display("FAIL bad3_no_lock: got %b expected 010", {gate_open, RED_LED, GREEN_LED}); end
    good_ticket(); step(); ticket_valid = 1'b0;
    checks++; if ({gate_open, RED_LED, GREEN_LED} !== 3'b101) begin errors++; $display("FAIL bad_then_good: got %b expected 101", {gate_open, RED_LED, GREEN_LED}); end
    sensor_exit_out = 1'b1; sensor_exit_in = 1'b0; step(); sensor_exit_out = 1'b0;
    checks++; if ({gate_open, RED_LED, GREEN_LED, occupancy} !== 7'b000_0110) begin errors++; $display("FAIL bad_exit: got %b occ=%0d expected 000 occ=6", {gate_open, RED_LED, GREEN_LED}, occupancy); end
`endif
  endtask

  task automatic test_async_reset();
    sensor_exit_in = 1'b1; step();
    good_ticket(); step(); ticket_valid = 1'b0;
    checks++; if (gate_open !== 1'b1) begin errors++; $display("FAIL pre_reset_open: got %b expected 1", gate_open); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if ({gate_open, RED_LED, GREEN_LED} !== 3'b000) begin errors++; $display("FAIL async_reset_outputs: got %b expected 000", {gate_open, RED_LED, GREEN_LED}); end
    checks++; if ({occupancy, empty} !== 5'b0000_1) begin errors++; $display("FAIL async_reset_occ: got occ=%0d empty=%b expected occ=0 empty=1", occupancy, empty); end
    sensor_exit_in = 1'b0;
    step();
    reset = 1'b1;
    step();
    checks++; if ({gate_open, RED_LED, GREEN_LED} !== 3'b000) begin errors++; $display("FAIL post_reset_idle: got %b expected 000", {gate_open, RED_LED, GREEN_LED}); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_empty_ignore();
    test_open_exit();
    test_timeout();
    test_full_saturate();
    test_sensor_drop();
    test_bad_tickets();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/parking_exit_gate.md
Name: parking_exit_gate

Overview:
Exit-side gate controller for the car park, complementing the entrance controller.
- Tracks occupancy from entrance "car_entered" pulses and exit passages.
- Validates a 2x2-bit exit ticket, drives the gate and the red/green exit LEDs.
- Sits beside the entrance FSM at top level; its occupancy/full flags feed the signage.

Parameters:
CAPACITY, 8, max cars tracked; occupancy saturates here
CNT_W, 4, occupancy width; must satisfy 2**CNT_W > CAPACITY
TIMEOUT_CYC, 4, cycles allowed in WAIT_TICKET before falling to BAD_TICKET
EXIT_CODE_1, 2'b10, required ticket_1 value
EXIT_CODE_2, 2'b01, required ticket_2 value
MAX_BAD_TICKETS, 3, wrong-ticket strobes before lockout (optional feature only)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset
car_entered  input  1  one-cycle pulse from entrance side: a car parked
sensor_exit_in  input  1  car present at exit barrier (level)
sensor_exit_out  input  1  car has passed barrier (level)
ticket_1  input  2  ticket field 1
ticket_2  input  2  ticket field 2
ticket_valid  input  1  one-cycle strobe qualifying ticket_1/ticket_2
gate_open  output  1  barrier raise command
GREEN_LED  output  1  exit green LED
RED_LED  output  1  exit red LED
occupancy  output  CNT_W  cars inside
full  output  1  occupancy == CAPACITY
empty  output  1  occupancy == 0

Behaviour:
- Reset (async, reset=0): state IDLE, occupancy 0, wait counter 0, gate_open 0, both LEDs 0. Reset asserted mid-operation aborts any open cycle immediately and closes the gate.
- States, 3-bit: IDLE=000, WAIT_TICKET=001, BAD_TICKET=010, OPEN=011, LOCKED=100 (LOCKED only reachable with the optional feature).
- "Good ticket" = ticket_valid & ticket_1==EXIT_CODE_1 & ticket_2==EXIT_CODE_2. "Bad ticket" = ticket_valid & !good.
- IDLE -> WAIT_TICKET when sensor_exit_in=1 and empty=0. If empty=1, sensor_exit_in is ignored and the state stays IDLE.
- WAIT_TICKET:
  - good -> OPEN.
  - bad -> BAD_TICKET.
  - sensor_exit_in=0 -> IDLE.
  - Wait counter increments each cycle in this state; when it reaches TIMEOUT_CYC-1 with no strobe -> BAD_TICKET. The counter clears in every other state.
  - Priority: good > bad > sensor drop > timeout.
- BAD_TICKET:
  - good -> OPEN.
  - sensor_exit_in=0 -> IDLE.
  - Otherwise stays.
- OPEN:
  - sensor_exit_out=1 -> IDLE and decrement occupancy.
  - Otherwise stays. Tickets are ignored.
- Occupancy arithmetic:
  - Increment on car_entered unless full (saturate; pulse dropped).
  - Decrement on OPEN exit unless empty.
  - Simultaneous increment and decrement -> unchanged.
  - No wrap-around in either direction.
- Outputs are registered and computed from next_state, so they change on the same edge as the state.
  - IDLE: gate 0, red 0, green 0.
  - WAIT_TICKET: gate 0, red 1, green 0.
  - BAD_TICKET: gate 0, green 0; red =1 on entry, then toggles every cycle.
  - OPEN: gate 1, red 0; green =1 on entry, then toggles every cycle.
  - LOCKED: gate 0, red 1, green 1, both steady.
- full and empty are combinational from the occupancy register.

Optional Feature:
- Macro: PARKING_EXIT_LOCKOUT_EN.
- Defined:
  - A bad-ticket counter increments on each bad strobe in WAIT_TICKET or BAD_TICKET.
  - The MAX_BAD_TICKETS-th bad strobe enters LOCKED instead of BAD_TICKET.
  - LOCKED ignores all tickets and returns to IDLE only when sensor_exit_in=0.
  - The counter clears on entering IDLE or OPEN.
- Undefined: no counter, LOCKED is unreachable, and bad tickets never lock.

Decomposition:
- Package parking_pkg holds:
  - the exit state encodings,
  - default EXIT_CODE_1/EXIT_CODE_2,
  - LED pattern constants.
- Sub-module parking_occupancy_counter holds the saturating up/down counter with CAPACITY/CNT_W and the full/empty flags; it is instantiated once.

Test Plan:
- Reset, 2 car_entered pulses, sensor_exit_in=1, good strobe (10/01) -> WAIT_TICKET then OPEN; gate_open=1, GREEN toggles 1,0,1; sensor_exit_out=1 -> IDLE, occupancy 2->1.
- occupancy=1, sensor_exit_in held 1, no strobe -> RED=1 for TIMEOUT_CYC (4) cycles, then BAD_TICKET with RED blinking; good strobe -> OPEN.
- empty=1, sensor_exit_in=1 -> stays IDLE, LEDs 0, gate_open 0.
- 9 car_entered pulses with CAPACITY=8 -> occupancy 8, full=1. Pulse on same cycle as OPEN exit -> occupancy stays 8.
- PARKING_EXIT_LOCKOUT_EN defined, 3 bad strobes (00/00) -> LOCKED, RED=GREEN=1; good strobe ignored; sensor_exit_in=0 -> IDLE.
- reset asserted while in OPEN with gate_open=1 -> gate_open=0, LEDs 0, occupancy 0 asynchronously.
